lol_scheduler: RTL
==================

# lol_scheduler

Arbitration and sequencing front-end for a single LOL symbol reader: two requesters each stream 3-bit symbol words (terminated by 000), and this block grants the reader to one requester per word, resets the reader before each word, flushes it afterwards, and classifies the result from the reader's L/O/Y outputs. It sits between the symbol sources and the reader and keeps saturating per-requester hit counts.

## Interface
- COUNT_W, 4, width of each hit counter
- MAX_SYM, 8, maximum non-terminator symbols accepted per grant before forced termination (1..15)
- clk  input  1  clock, all state on rising edge
- restart  input  1  synchronous, active-high reset
- req0_bits  input  3  requester 0 symbol
- req0_valid  input  1  requester 0 symbol/word pending
- req0_ready  output  1  requester 0 symbol accepted this cycle when valid
- req1_bits, req1_valid, req1_ready  same as requester 0, for requester 1
- rd_bits  output  3  symbol to reader (registered)
- rd_restart  output  1  restart to reader
- L, O, Y  input  1 each  reader end-of-word flags
- grant  output  2  one-hot current owner (bit0 = req0), 00 when idle
- done  output  1  one-cycle pulse: word classified
- done_owner  output  1  requester of completed word
- kind  output  2  00 none/garbage, 01 L, 10 O, 11 Y
- timeout  output  1  one-cycle pulse with done when word was force-terminated
- hits0, hits1  output  COUNT_W  saturating count of recognized (kind≠00) words per requester

## Operation
- States: IDLE, RST, FWD, FLUSH, SAMPLE.
- IDLE: ready=0. If any reqX_valid: choose owner round-robin (requester not served last wins tie; a lone requester wins); grant<=owner; ->RST. Last-served pointer resets to 1 (req0 wins first tie).
- RST: rd_restart=1 (decoded from state), ready=0; ->FWD; symbol counter cleared.
- FWD: owner ready=1 while count<MAX_SYM; other ready=0.
  - valid & bits≠000: accepted; rd_bits<=bits; count+1.
  - valid & bits=000: accepted terminator; rd_bits<=000; ->FLUSH.
  - valid=0 (bubble): treated as terminator (reader cannot stall); rd_bits<=000; ->FLUSH.
  - count==MAX_SYM: ready=0, forced terminator, rd_bits<=000, abort flag set; ->FLUSH.
- FLUSH: rd_bits=000 presented to reader; ->SAMPLE.
- SAMPLE: capture L/O/Y; kind = Y?11 : O?10 : L?01 : 00; kind forced 00 if abort. If kind≠00 increment owner's hit counter, saturating at 2^COUNT_W−1. Update last-served; ->IDLE.
- rd_bits is 000 whenever no symbol is being forwarded.
- Only owner's ready may be high; never both.

## Timing
- Reset (restart=1 at a rising edge): state IDLE, grant=00, rd_bits=000, rd_restart=0, done=0, kind=00, done_owner=0, timeout=0, hits0=hits1=0, ready=0 next cycle; overrides any in-progress word.
- Request seen in IDLE cycle a: grant valid and RST in a+1; FWD (first accept possible) in a+2.
- Symbol accepted in cycle t appears on rd_bits in t+1.
- Terminator/bubble/forced end in cycle t: FLUSH t+1, SAMPLE t+2 (L/O/Y sampled), done/kind/done_owner/timeout and updated hits visible t+3, one cycle. State IDLE in t+3; arbitration in t+3 may grant in t+4.
- Minimum word turnaround (RST to next RST): 5 cycles plus symbols.
- reqX_ready combinational from state/count only (not from valid).
- Requester must hold bits/valid stable in IDLE until accepted.

## Test plan
- Reset, req0 sends 111,001,000 → rd_bits 111,001,000 one cycle behind acceptance; done=1 three cycles after terminator, kind=01, done_owner=0, hits0=1.
- Both valid same cycle: req0 sends 111,101,111,000, req1 sends 100,011,100,000 → req0 granted first (kind=10), then req1 (kind=11); hits0=1, hits1=1; grant never 11.
- req1 garbage 111,010,000 → kind=00, hits1 unchanged; then 100,011,100,000 → kind=11, hits1=1.
- MAX_SYM=8, req0 streams 111 continuously → exactly 8 accepts, req0_ready low from 9th cycle, done with timeout=1, kind=00.
- Bubble: req0 sends 100 then valid=0 → word ends, kind=00; subsequent 011 starts a new grant.
- restart asserted mid-FWD → next cycle grant=00, ready=0, rd_bits=000, hits0=hits1=0; COUNT_W=4 with 17 L words → hits0 saturates at 15.

Source files
------------

// File: rtl/lol_scheduler.sv
// lol_scheduler: round-robin front-end for a single LOL symbol reader.
// Grants one requester per word, brackets the word with reader restart/flush and classifies it.
module lol_scheduler #(
  parameter int COUNT_W = 4,
  parameter int MAX_SYM = 8
) (
  input  logic               clk,
  input  logic               restart,
  input  logic [2:0]         req0_bits,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [2:0]         req1_bits,
  input  logic               req1_valid,
  output logic               req1_ready,
  output logic [2:0]         rd_bits,
  output logic               rd_restart,
  input  logic               L,
  input  logic               O,
  input  logic               Y,
  output logic [1:0]         grant,
  output logic               done,
  output logic               done_owner,
  output logic [1:0]         kind,
  output logic               timeout,
  output logic [COUNT_W-1:0] hits0,
  output logic [COUNT_W-1:0] hits1
);

  typedef enum logic [2:0] {S_IDLE, S_RST, S_FWD, S_FLUSH, S_SAMPLE} state_t;

  localparam logic [COUNT_W-1:0] HITS_MAX = '1;

  state_t     r_state;
  state_t     w_next;
  logic       r_owner;
  logic       r_last;
  logic       r_abort;
  logic [3:0] r_cnt;
  logic       w_full;
  logic       w_fwd_ready;
  logic       w_owner_valid;
  logic [2:0] w_owner_bits;
  logic       w_pick;
  logic [1:0] w_kind;

  assign w_full        = (r_cnt == 4'(MAX_SYM));
  assign w_owner_valid = r_owner ? req1_valid : req0_valid;
  assign w_owner_bits  = r_owner ? req1_bits : req0_bits;
  // On a tie the requester not served last wins; a lone requester always wins.
  assign w_pick        = (req0_valid && req1_valid) ? ~r_last : req1_valid;

  assign w_kind = r_abort ? 2'b00 :
                  Y       ? 2'b11 :
                  O       ? 2'b10 :
                  L       ? 2'b01 : 2'b00;

  assign grant      = (r_state == S_IDLE) ? 2'b00 : (r_owner ? 2'b10 : 2'b01);
  assign req0_ready = w_fwd_ready && !r_owner;
  assign req1_ready = w_fwd_ready && r_owner;

  always_ff @(posedge clk) begin
    if (restart) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    w_next      = r_state;
    rd_restart  = 1'b0;
    w_fwd_ready = 1'b0;
    case (r_state)
      S_IDLE:   if (req0_valid || req1_valid) w_next = S_RST;
      S_RST: begin
        rd_restart = 1'b1;
        w_next     = S_FWD;
      end
      S_FWD: begin
        w_fwd_ready = !w_full;
        if (w_full || !w_owner_valid || (w_owner_bits == 3'b000)) w_next = S_FLUSH;
      end
      S_FLUSH:  w_next = S_SAMPLE;
      S_SAMPLE: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (restart) begin
      r_owner    <= 1'b0;
      r_last     <= 1'b1;
      r_cnt      <= 4'd0;
      r_abort    <= 1'b0;
      rd_bits    <= 3'b000;
      done       <= 1'b0;
      timeout    <= 1'b0;
      kind       <= 2'b00;
      done_owner <= 1'b0;
      hits0      <= '0;
      hits1      <= '0;
    end else begin
      rd_bits <= 3'b000;
      done    <= 1'b0;
      timeout <= 1'b0;
      case (r_state)
        S_IDLE: if (req0_valid || req1_valid) r_owner <= w_pick;
        S_RST: begin
          r_cnt   <= 4'd0;
          r_abort <= 1'b0;
        end
        S_FWD: begin
          if (w_full) begin
            r_abort <= 1'b1;
          end else if (w_owner_valid && (w_owner_bits != 3'b000)) begin
            rd_bits <= w_owner_bits;
            r_cnt   <= r_cnt + 4'd1;
          end
        end
        S_SAMPLE: begin
          done       <= 1'b1;
          timeout    <= r_abort;
          kind       <= w_kind;
          done_owner <= r_owner;
          r_last     <= r_owner;
          if (w_kind != 2'b00) begin
            if (r_owner) begin
              if (hits1 != HITS_MAX) hits1 <= hits1 + 1'b1;
            end else begin
              if (hits0 != HITS_MAX) hits0 <= hits0 + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
